relu_maxpool: RTL and testbench
===============================

Name: relu_maxpool

Overview:
Consumes the raster-ordered stream of signed convolution results (one word per valid pulse) from the convolution stage. Applies ReLU to each word, then 2x2 max-pooling with stride 2, and emits the pooled feature map in raster order. One frame is FMAP x FMAP inputs and produces (FMAP/2) x (FMAP/2) outputs; a done flag follows the last output. No back-pressure exists: the block accepts one input per cycle, sustained.

Parameters:
FMAP, 12, input feature-map width and height (N-M+1 of the convolution stage); must be even.
DW, 13, signed data width of input and output words.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
in_data  input  DW  signed convolution result; valid only when in_valid=1.
in_valid  input  1  one-cycle strobe, one per element, raster order (row-major, col 0..FMAP-1).
out_data  output  DW  signed pooled result; always >= 0 after ReLU.
out_valid  output  1  one-cycle strobe qualifying out_data.
done  output  1  sticky; set once the frame's last pooled output has been issued.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - out_data=0, out_valid=0, done=0.
  - col=0, row=0, state=S_RUN.
  - Line-buffer contents are don't-care; every entry is written before it is read.
- ReLU: r = (in_data < 0) ? 0 : in_data. This is a signed compare; -4096 maps to 0. No widening is needed, and the max of non-negatives stays within DW.
- Counters:
  - col counts 0..FMAP-1 and advances only on an accepted in_valid.
  - At col=FMAP-1, col wraps to 0 and row increments.
  - At row=FMAP-1 with col=FMAP-1, the frame is complete.
- Datapath (all updates occur on an accepted in_valid only):
  - Even row, even col: tmp <= r.
  - Even row, odd col: hbuf[col>>1] <= max(tmp, r). hbuf is a FMAP/2-entry register line buffer.
  - Odd row, even col: tmp <= r.
  - Odd row, odd col: out_data <= max(hbuf[col>>1], max(tmp, r)) and out_valid <= 1 on the same edge.
- Latency: out_valid is high in the cycle after the clock edge that accepted the bottom-right element of each 2x2 window.
- out_valid is high for exactly one cycle. out_data holds its value until the next output.
- State machine:
  - S_RUN: accepts inputs. On the edge that accepts the element at row=FMAP-1, col=FMAP-1, go to S_DONE. That same edge issues the final out_valid.
  - S_DONE: done <= 1 on the entry edge, so done rises together with the final out_valid. in_valid is ignored: no counter, buffer, or output change. S_DONE is left only by rst.
- in_valid=0: no state change, and out_valid=0 on the next cycle.
- Back-to-back in_valid (every cycle) and sparse in_valid (e.g. once every 50+ cycles) must yield identical output sequences.
- Reset mid-frame: the partial frame is discarded. The next in_valid after reset is treated as element (0,0). No stale pooled value may be emitted.
- rst has priority over in_valid arriving in the same cycle; that input is dropped.
- Outputs per frame: exactly (FMAP/2)^2, which is 36 at the default.

Test Plan:
- Ramp frame: in_data = row*12+col for all 144 elements, back-to-back -> 36 outputs 13,15,...,23,37,...,143 (value (2i+1)*12+2j+1). done rises with the 36th out_valid.
- All negative: 144 inputs of -5, plus one element of -4096 -> 36 outputs of 0, then done=1.
- Single peak: background -1, in_data=4095 at (row 3, col 4) -> output index 8 (pool row 1, col 2) = 4095; all other 35 outputs = 0.
- Sparse timing: the ramp frame with in_valid every 53 cycles -> the same 36 values as the first scenario. Each out_valid is exactly 1 cycle after the odd-row/odd-col input, and out_valid=0 in all other cycles.
- Mid-frame reset: rst after 50 ramp inputs, then a full ramp frame -> exactly 36 outputs matching the first scenario. done=0 until the 36th.
- Post-done: 10 extra in_valid pulses after done -> no out_valid, and done stays 1. A following rst clears done to 0 and out_valid to 0.

Source files
------------

// File: rtl/relu_maxpool.sv
// rtl/relu_maxpool.sv - ReLU followed by 2x2 stride-2 max-pooling over a raster-ordered frame
module relu_maxpool #(
    parameter int FMAP = 12,
    parameter int DW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          done
);

    localparam int CW = (FMAP > 2) ? $clog2(FMAP) : 2;
    localparam int HW = FMAP / 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(FMAP - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]        r_col;
    logic [CW-1:0]        r_row;
    logic signed [DW-1:0] r_tmp;
    logic signed [DW-1:0] r_hbuf [HW];
    logic [DW-1:0]        r_out_data;
    logic                 r_out_valid;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_frame_end;
    logic [CW-2:0]        w_hidx;
    logic signed [DW-1:0] w_relu;
    logic signed [DW-1:0] w_pair_max;
    logic signed [DW-1:0] w_pool_max;

    // Signed maximum of two words; both operands are already non-negative here.
    function automatic logic signed [DW-1:0] smax(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign w_col_last  = (r_col == LAST_IDX);
    assign w_frame_end = w_col_last && (r_row == LAST_IDX);
    assign w_hidx      = r_col[CW-1:1];

    // Negative inputs clamp to zero; the sign bit alone decides.
    assign w_relu      = in_data[DW-1] ? '0 : $signed(in_data);
    assign w_pair_max  = smax(r_tmp, w_relu);
    assign w_pool_max  = smax(r_hbuf[w_hidx], w_pair_max);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and input acceptance; inputs are ignored once the frame is complete.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_RUN: begin
                w_accept = in_valid;
                if (in_valid && w_frame_end) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // Raster position counters, advanced only on accepted inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Horizontal pair register and half-width line buffer; contents need no reset
    // because every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (!r_col[0]) begin
                r_tmp <= w_relu;
            end else if (!r_row[0]) begin
                r_hbuf[w_hidx] <= w_pair_max;
            end
        end
    end

    // Pooled output: issued on the bottom-right element of each 2x2 window, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && r_row[0] && r_col[0]) begin
                r_out_data  <= w_pool_max;
                r_out_valid <= 1'b1;
            end
        end
    end

    // Sticky completion flag, rising with the final pooled output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (w_accept && w_frame_end) begin
            r_done <= 1'b1;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb/tb_relu_maxpool.sv - self-checking bench for relu_maxpool using an expected-output queue
module tb_relu_maxpool;

    localparam int FMAP = 12;
    localparam int DW   = 13;
    localparam int NOUT = (FMAP / 2) * (FMAP / 2);

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          done;

    relu_maxpool #(.FMAP(FMAP), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    // Reference model state
    int q_exp[$];
    int m_frame [FMAP][FMAP];
    int m_row;
    int m_col;
    bit m_done;

    // Per-cycle expectations set by the driver alongside the input
    bit tb_exp_v;
    bit tb_last;
    bit mon_v;
    bit mon_done;
    bit mon_en;
    logic [DW-1:0] last_out;

    // Expectations become visible one edge after the input is taken.
    always @(posedge clk) begin
        if (rst) begin
            mon_v    <= 1'b0;
            mon_done <= 1'b0;
        end else begin
            mon_v    <= tb_exp_v;
            mon_done <= mon_done | tb_last;
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int e;
            logic [DW-1:0] ew;
            n_checks++;
            if (out_valid !== mon_v) begin
                n_fail++;
                $display("FAIL out_valid_timing t=%0t got %b expected %b", $time, out_valid, mon_v);
            end
            n_checks++;
            if (done !== mon_done) begin
                n_fail++;
                $display("FAIL done_flag t=%0t got %b expected %b", $time, done, mon_done);
            end
            if (out_valid === 1'b1) begin
                n_out++;
                n_checks++;
                if (q_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output t=%0t got %0d expected no output", $time, out_data);
                end else begin
                    e  = q_exp.pop_front();
                    ew = DW'(e);
                    if (out_data !== ew) begin
                        n_fail++;
                        $display("FAIL pooled_value t=%0t got %0d expected %0d", $time, out_data, ew);
                    end
                end
                last_out = out_data;
            end else begin
                n_checks++;
                if (out_data !== last_out) begin
                    n_fail++;
                    $display("FAIL out_data_hold t=%0t got %0d expected %0d", $time, out_data, last_out);
                end
            end
            if (rst) last_out = '0;
        end
    end

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_clear();
        m_row  = 0;
        m_col  = 0;
        m_done = 1'b0;
    endtask

    // Drive one accepted element and predict the result from the stored window.
    task automatic drive(input int v);
        logic [DW-1:0] vw;
        @(posedge clk);
        #1;
        vw       = DW'(v);
        in_data  = vw;
        in_valid = 1'b1;
        tb_exp_v = 1'b0;
        tb_last  = 1'b0;
        if (!m_done) begin
            m_frame[m_row][m_col] = relu(v);
            if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                q_exp.push_back(max2(max2(m_frame[m_row-1][m_col-1], m_frame[m_row-1][m_col]),
                                     max2(m_frame[m_row][m_col-1],   m_frame[m_row][m_col])));
                tb_exp_v = 1'b1;
            end
            if (m_row == FMAP - 1 && m_col == FMAP - 1) begin
                m_done  = 1'b1;
                tb_last = 1'b1;
            end
            if (m_col == FMAP - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            tb_exp_v = 1'b0;
            tb_last  = 1'b0;
        end
    endtask

    // One-cycle reset with a valid input presented at the same time; that input must be dropped.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(777);
        tb_exp_v = 1'b0;
        tb_last  = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL queue_at_reset got %0d pending expected 0", q_exp.size());
        end
        q_exp.delete();
        model_clear();
    endtask

    task automatic check_frame_end(input string name, input int start_out);
        idle(3);
        n_checks++;
        if (n_out - start_out != NOUT) begin
            n_fail++;
            $display("FAIL %s_output_count got %0d expected %0d", name, n_out - start_out, NOUT);
        end
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_outputs got %0d pending expected 0", name, q_exp.size());
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_final got %b expected 1", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data got %0d expected 0", out_data);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b expected 0", done);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_ramp();
        int s;
        do_reset();
        s = n_out;
        for (int r = 0; r < FMAP; r++)
            for (int c = 0; c < FMAP; c++)
                drive(r * FMAP + c);
        check_frame_end("ramp", s);
    endtask

    task automatic test_all_negative();
        int s;
        do_reset();
        s = n_out;
        for (int r = 0; r < FMAP; r++)
            for (int c = 0; c < FMAP; c++)
                drive((r == 5 && c == 7) ? -4096 : -5);
        check_frame_end("negative", s);
    endtask

    task automatic test_single_peak();
        int s;
        do_reset();
        s = n_out;
        for (int r = 0; r < FMAP; r++)
            for (int c = 0; c < FMAP; c++)
                drive((r == 3 && c == 4) ? 4095 : -1);
        check_frame_end("peak", s);
    endtask

    task automatic test_sparse();
        int s;
        do_reset();
        s = n_out;
        for (int r = 0; r < FMAP; r++)
            for (int c = 0; c < FMAP; c++) begin
                drive(r * FMAP + c);
                idle(52);
            end
        check_frame_end("sparse", s);
    endtask

    task automatic test_mid_reset();
        int s;
        do_reset();
        for (int k = 0; k < 50; k++)
            drive(k);
        idle(2);
        do_reset();
        s = n_out;
        for (int r = 0; r < FMAP; r++)
            for (int c = 0; c < FMAP; c++)
                drive(r * FMAP + c);
        check_frame_end("midreset", s);
    endtask

    task automatic test_post_done();
        int s;
        do_reset();
        for (int r = 0; r < FMAP; r++)
            for (int c = 0; c < FMAP; c++)
                drive(r * FMAP + c);
        idle(2);
        s = n_out;
        for (int k = 0; k < 10; k++)
            drive(-100 + 37 * k);
        idle(2);
        n_checks++;
        if (n_out != s) begin
            n_fail++;
            $display("FAIL postdone_outputs got %0d expected 0", n_out - s);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL postdone_done got %b expected 1", done);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL postdone_reset_done got %b expected 0", done);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL postdone_reset_valid got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL postdone_reset_data got %0d expected 0", out_data);
        end
    endtask

    // Spot-check the ramp pooling closed form against the window model.
    task automatic test_ramp_formula();
        for (int i = 0; i < FMAP / 2; i++)
            for (int j = 0; j < FMAP / 2; j++) begin
                int e;
                e = max2(max2(m_frame[2*i][2*j], m_frame[2*i][2*j+1]),
                         max2(m_frame[2*i+1][2*j], m_frame[2*i+1][2*j+1]));
                n_checks++;
                if (e != (2 * i + 1) * FMAP + 2 * j + 1) begin
                    n_fail++;
                    $display("FAIL ramp_formula i=%0d j=%0d got %0d expected %0d",
                             i, j, e, (2 * i + 1) * FMAP + 2 * j + 1);
                end
            end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tb_exp_v = 1'b0;
        tb_last  = 1'b0;
        mon_en   = 1'b0;
        last_out = '0;
        model_clear();

        test_reset();
        test_ramp();
        test_ramp_formula();
        test_all_negative();
        test_single_peak();
        test_sparse();
        test_mid_reset();
        test_post_done();

        idle(2);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
